// File: rtl/alu.sv
// rtl/alu.sv - 32-bit integer ALU with registered result and optional status flags
//
// Purpose:
//   One operation per cycle selected by mode; operands sampled on the rising
//   edge of clk, result (and flags) registered with one cycle of latency.
//   Fully pipelined, no backpressure.
//
// Configuration macro:
//   ALU_FLAGS_EN - when defined, zero/negative/carry/overflow ports and their
//                  registers are present; when undefined they are omitted.
//
// Ports:
//   clk        in   1      clock, all state on rising edge
//   rst_n      in   1      synchronous active-low reset
//   in_valid   in   1      a/b/mode valid this cycle
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B / shift amount (low $clog2(WIDTH) bits)
//   mode       in   3      000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR,
//                          101 SLL, 110 SRL, 111 SRA
//   q          out  WIDTH  registered result
//   out_valid  out  1      in_valid delayed one cycle
//   zero       out  1      q == 0            (ALU_FLAGS_EN)
//   negative   out  1      q[WIDTH-1]        (ALU_FLAGS_EN)
//   carry      out  1      ADD carry-out / SUB no-borrow (ALU_FLAGS_EN)
//   overflow   out  1      signed overflow for ADD/SUB   (ALU_FLAGS_EN)

module alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       mode,
    output logic [WIDTH-1:0] q,
    output logic             out_valid
`ifdef ALU_FLAGS_EN
    ,
    output logic             zero,
    output logic             negative,
    output logic             carry,
    output logic             overflow
`endif
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SRL = 3'b110;
    localparam logic [2:0] OP_SRA = 3'b111;

    logic [WIDTH-1:0] q_q, q_d;
    logic             valid_q;
    logic [SHW-1:0]   shamt;

    // Upper bits of b are deliberately ignored for shifts.
    assign shamt = b[SHW-1:0];

    always_comb begin
        q_d = '0;
        case (mode)
            OP_ADD:  q_d = a + b;
            OP_SUB:  q_d = a - b;
            OP_AND:  q_d = a & b;
            OP_OR:   q_d = a | b;
            OP_XOR:  q_d = a ^ b;
            OP_SLL:  q_d = a << shamt;
            OP_SRL:  q_d = a >> shamt;
            OP_SRA:  q_d = $unsigned($signed(a) >>> shamt);
            default: q_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                q_q <= q_d;
            end
        end
    end

    assign q         = q_q;
    assign out_valid = valid_q;

`ifdef ALU_FLAGS_EN
    logic [WIDTH:0] sum_ext;
    logic [WIDTH:0] diff_ext;
    logic           carry_d;
    logic           ovf_d;
    logic           zero_q, neg_q, carry_q, ovf_q;

    // One extra bit captures the ADD carry-out; for SUB the extra bit is the
    // borrow, so carry is its inverse (1 when a >= b unsigned).
    assign sum_ext  = {1'b0, a} + {1'b0, b};
    assign diff_ext = {1'b0, a} - {1'b0, b};

    always_comb begin
        carry_d = 1'b0;
        ovf_d   = 1'b0;
        case (mode)
            OP_ADD: begin
                carry_d = sum_ext[WIDTH];
                ovf_d   = (a[WIDTH-1] == b[WIDTH-1]) &&
                          (sum_ext[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                carry_d = ~diff_ext[WIDTH];
                ovf_d   = (a[WIDTH-1] != b[WIDTH-1]) &&
                          (diff_ext[WIDTH-1] != a[WIDTH-1]);
            end
            default: begin
                carry_d = 1'b0;
                ovf_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            zero_q  <= 1'b1;
            neg_q   <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (in_valid) begin
            zero_q  <= (q_d == '0);
            neg_q   <= q_d[WIDTH-1];
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

    assign zero     = zero_q;
    assign negative = neg_q;
    assign carry    = carry_q;
    assign overflow = ovf_q;
`endif

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - self-checking testbench for alu against a behavioural model

module tb_alu;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  mode;
    logic [31:0] q;
    logic        out_valid;
    logic [3:0]  flags_obs;   // {zero, negative, carry, overflow}

    int errors = 0;
    int checks = 0;

`ifdef ALU_FLAGS_EN
    localparam bit HAS_FLAGS = 1'b1;
    logic zero, negative, carry, overflow;
    assign flags_obs = {zero, negative, carry, overflow};

    alu #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .a(a), .b(b), .mode(mode),
        .q(q), .out_valid(out_valid),
        .zero(zero), .negative(negative), .carry(carry), .overflow(overflow)
    );
`else
    localparam bit HAS_FLAGS = 1'b0;
    assign flags_obs = 4'b0000;

    alu #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .a(a), .b(b), .mode(mode),
        .q(q), .out_valid(out_valid)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: what the outputs should show after the most recent edge.
    logic [31:0] exp_q;
    logic        exp_v;
    logic [3:0]  exp_f;

    // Reference computed with wide plain arithmetic: results are range-checked
    // in 64-bit integers instead of inspecting individual sign bits.
    function automatic logic [35:0] ref_op(input logic [31:0] ra, input logic [31:0] rb,
                                           input logic [2:0] rm);
        longint unsigned ua = ra;
        longint unsigned ub = rb;
        longint          sa = longint'($signed(ra));
        longint          sb = longint'($signed(rb));
        longint          sr;
        longint unsigned ur;
        int unsigned     sh = rb % 32;
        logic [31:0]     r = 32'h0;
        logic            c = 1'b0;
        logic            v = 1'b0;
        case (rm)
            3'd0: begin
                ur = ua + ub; r = ur[31:0]; c = (ur >= 64'h1_0000_0000);
                sr = sa + sb; v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            3'd1: begin
                r = ra - rb; c = (ua >= ub);
                sr = sa - sb; v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
            end
            3'd2: r = ra & rb;
            3'd3: r = ra | rb;
            3'd4: r = ra ^ rb;
            3'd5: r = ra << sh;
            3'd6: r = ra >> sh;
            default: begin
                sr = sa / (64'sd1 << sh);
                if ((sa < 0) && (sa % (64'sd1 << sh) != 0)) sr = sr - 1;
                r = sr[31:0];
            end
        endcase
        return {r, (r == 32'h0), r[31], c, v};
    endfunction

    // Drive one cycle of inputs at the falling edge, let the rising edge
    // sample them, and advance the model to match.
    task automatic step(input logic rn, input logic v, input logic [31:0] sa,
                        input logic [31:0] sb, input logic [2:0] sm);
        logic [35:0] r;
        @(negedge clk);
        rst_n = rn; in_valid = v; a = sa; b = sb; mode = sm;
        @(posedge clk);
        #1;
        if (!rn) begin
            exp_q = 32'h0; exp_v = 1'b0; exp_f = 4'b1000;
        end else if (v) begin
            r = ref_op(sa, sb, sm);
            exp_q = r[35:4]; exp_v = 1'b1; exp_f = r[3:0];
        end else begin
            exp_v = 1'b0;
        end
    endtask

    function automatic logic [3:0] fmask(input logic [3:0] f);
        return HAS_FLAGS ? f : 4'b0000;
    endfunction

    task automatic test_reset;
        step(1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
        step(1'b0, 1'b1, 32'h1234_5678, 32'h1, 3'd0);
        checks++;
        if ({q, out_valid, flags_obs} !== {32'h0, 1'b0, fmask(4'b1000)}) begin
            errors++;
            $display("FAIL reset: q=%h v=%b f=%b required q=00000000 v=0 f=%b",
                     q, out_valid, flags_obs, fmask(4'b1000));
        end
    endtask

    task automatic test_sweep;
        logic [31:0] want_q [8];
        logic [3:0]  want_f [8];
        want_q = '{32'h000010E2, 32'hFFFFEF1C, 32'h000010E3, 32'hFFFFFFFF,
                   32'hFFFFEF1C, 32'hFFFFFFF8, 32'h1FFFFFFF, 32'hFFFFFFFF};
        want_f = '{4'b0010, 4'b0110, 4'b0000, 4'b0100,
                   4'b0100, 4'b0100, 4'b0000, 4'b0100};
        for (int m = 0; m < 8; m++) begin
            step(1'b1, 1'b1, 32'hFFFFFFFF, 32'h000010E3, 3'(m));
            checks++;
            if ({q, out_valid, flags_obs} !== {want_q[m], 1'b1, fmask(want_f[m])}) begin
                errors++;
                $display("FAIL sweep mode=%0d: q=%h v=%b f=%b required q=%h v=1 f=%b",
                         m, q, out_valid, flags_obs, want_q[m], fmask(want_f[m]));
            end
        end
    endtask

    task automatic test_corners;
        step(1'b1, 1'b1, 32'h7FFFFFFF, 32'h1, 3'd0);
        checks++;
        if ({q, out_valid, flags_obs} !== {32'h80000000, 1'b1, fmask(4'b0101)}) begin
            errors++;
            $display("FAIL add_ovf: q=%h v=%b f=%b required q=80000000 f=%b",
                     q, out_valid, flags_obs, fmask(4'b0101));
        end
        step(1'b1, 1'b1, 32'h5, 32'h5, 3'd1);
        checks++;
        if ({q, out_valid, flags_obs} !== {32'h0, 1'b1, fmask(4'b1010)}) begin
            errors++;
            $display("FAIL sub_zero: q=%h v=%b f=%b required q=00000000 f=%b",
                     q, out_valid, flags_obs, fmask(4'b1010));
        end
        step(1'b1, 1'b1, 32'h1, 32'hFFFFFFE0, 3'd5);
        checks++;
        if ({q, out_valid} !== {32'h1, 1'b1}) begin
            errors++;
            $display("FAIL sll_upper_bits: q=%h v=%b required q=00000001 v=1", q, out_valid);
        end
        step(1'b1, 1'b1, 32'h80000000, 32'h1F, 3'd7);
        checks++;
        if ({q, out_valid} !== {32'hFFFFFFFF, 1'b1}) begin
            errors++;
            $display("FAIL sra_31: q=%h v=%b required q=ffffffff v=1", q, out_valid);
        end
    endtask

    task automatic test_valid_pulse;
        logic [31:0] held;
        step(1'b1, 1'b1, 32'h0000_0003, 32'h0000_0004, 3'd0);
        held = 32'h7;
        checks++;
        if ({q, out_valid} !== {held, 1'b1}) begin
            errors++;
            $display("FAIL pulse_first: q=%h v=%b required q=%h v=1", q, out_valid, held);
        end
        step(1'b1, 1'b0, 32'hDEAD_BEEF, 32'h1, 3'd1);
        checks++;
        if ({q, out_valid, flags_obs} !== {held, 1'b0, fmask(4'b0000)}) begin
            errors++;
            $display("FAIL pulse_hold: q=%h v=%b f=%b required q=%h v=0 f=%b",
                     q, out_valid, flags_obs, held, fmask(4'b0000));
        end
        step(1'b1, 1'b1, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 3'd3);
        checks++;
        if ({q, out_valid} !== {32'hFFFFFFFF, 1'b1}) begin
            errors++;
            $display("FAIL pulse_second: q=%h v=%b required q=ffffffff v=1", q, out_valid);
        end
    endtask

    task automatic test_reset_priority;
        step(1'b1, 1'b1, 32'h1, 32'h2, 3'd0);
        step(1'b0, 1'b1, 32'h1111_1111, 32'h2222_2222, 3'd0);
        checks++;
        if ({q, out_valid, flags_obs} !== {32'h0, 1'b0, fmask(4'b1000)}) begin
            errors++;
            $display("FAIL reset_wins: q=%h v=%b f=%b required q=00000000 v=0 f=%b",
                     q, out_valid, flags_obs, fmask(4'b1000));
        end
        step(1'b1, 1'b1, 32'hA, 32'h3, 3'd1);
        checks++;
        if ({q, out_valid} !== {32'h7, 1'b1}) begin
            errors++;
            $display("FAIL resume_after_reset: q=%h v=%b required q=00000007 v=1", q, out_valid);
        end
    endtask

    task automatic test_random;
        logic [31:0] ra, rb;
        logic        rv;
        for (int i = 0; i < 400; i++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 3))
                0: ra = {ra[31], 31'h7FFFFFFF} ^ {1'b0, ra[30:0] & 31'h3};
                1: rb = ra;
                default: ;
            endcase
            rv = ($urandom_range(0, 4) != 0);
            step(1'b1, rv, ra, rb, 3'($urandom_range(0, 7)));
            checks++;
            if ({q, out_valid, flags_obs} !== {exp_q, exp_v, fmask(exp_f)}) begin
                errors++;
                $display("FAIL random #%0d a=%h b=%h m=%0d v=%b: q=%h v=%b f=%b required q=%h v=%b f=%b",
                         i, ra, rb, mode, rv, q, out_valid, flags_obs,
                         exp_q, exp_v, fmask(exp_f));
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; mode = '0;
        exp_q = '0; exp_v = 1'b0; exp_f = 4'b1000;
        test_reset;
        test_sweep;
        test_corners;
        test_valid_pulse;
        test_reset_priority;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
